// File: rtl/audio_pkg.sv
// Shared audio/game definitions: state codes, ROM address width, clip ranges.
// Also imported by the game FSM so both sides agree on the state encoding.
package audio_pkg;

  localparam int ADDR_W = 23;

  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [3:0] {
    GS_IDLE        = 4'd0,
    GS_START_DELAY = 4'd1,
    GS_PLAY0       = 4'd2,
    GS_PLAY1       = 4'd3,
    GS_PLAY2       = 4'd4,
    GS_MISSED      = 4'd5,
    GS_WHACKED     = 4'd6,
    GS_SAFE_STEP   = 4'd7,
    GS_GAME_OVER   = 4'd8,
    GS_HOLD0       = 4'd9,
    GS_HOLD1       = 4'd10
  } game_state_e;

  typedef enum logic [1:0] {
    SEQ_SILENT,
    SEQ_MUSIC,
    SEQ_SFX
  } seq_state_e;

  typedef struct packed {
    addr_t start;
    addr_t last;
  } clip_t;

  localparam addr_t DEF_MUSIC_START = 23'h00000;
  localparam addr_t DEF_MUSIC_END   = 23'h4FFFF;
  localparam addr_t DEF_WHACK_START = 23'h50000;
  localparam addr_t DEF_WHACK_END   = 23'h51FFF;
  localparam addr_t DEF_MISS_START  = 23'h52000;
  localparam addr_t DEF_MISS_END    = 23'h53FFF;
  localparam addr_t DEF_OVER_START  = 23'h54000;
  localparam addr_t DEF_OVER_END    = 23'h57FFF;

  function automatic logic is_audible(logic [3:0] gs);
    return (gs >= GS_PLAY0 && gs <= GS_SAFE_STEP)
        || gs == GS_HOLD0
        || gs == GS_HOLD1;
  endfunction

  function automatic logic is_quiet(logic [3:0] gs);
    return gs == GS_IDLE || gs == GS_START_DELAY;
  endfunction

  function automatic logic ends_silent(logic [3:0] gs);
    return is_quiet(gs) || gs == GS_GAME_OVER;
  endfunction

endpackage

// File: rtl/sample_fetch.sv
// Two-cycle fetch/capture pipeline: registers the ROM address on issue
// and captures rom_data two clocks later, muted issues capture zero.
module sample_fetch
  import audio_pkg::*;
#(
  parameter addr_t RESET_ADDR = DEF_MUSIC_START
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ready_i,
  input  logic              mute_i,
  input  addr_t             addr_i,
  input  logic signed [7:0] rom_data_i,
  output addr_t             rom_address_o,
  output logic signed [7:0] sample_o
);

  addr_t             addr_q;
  logic [1:0]        vld_q;
  logic [1:0]        mute_q;
  logic signed [7:0] sample_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= RESET_ADDR;
      vld_q    <= '0;
      mute_q   <= '0;
      sample_q <= '0;
    end else begin
      if (ready_i && !mute_i) begin
        addr_q <= addr_i;
      end
      vld_q  <= {vld_q[0], ready_i};
      mute_q <= {mute_q[0], mute_i};
      if (vld_q[1]) begin
        sample_q <= mute_q[1] ? 8'sd0 : rom_data_i;
      end
    end
  end

  assign rom_address_o = addr_q;
  assign sample_o      = sample_q;

endmodule

// File: rtl/audio_sequencer.sv
// Background music / sound-effect sequencer feeding the codec.
// Effects preempt music; music position is kept while an effect plays.
module audio_sequencer
  import audio_pkg::*;
#(
  parameter addr_t MUSIC_START = DEF_MUSIC_START,
  parameter addr_t MUSIC_END   = DEF_MUSIC_END,
  parameter addr_t WHACK_START = DEF_WHACK_START,
  parameter addr_t WHACK_END   = DEF_WHACK_END,
  parameter addr_t MISS_START  = DEF_MISS_START,
  parameter addr_t MISS_END    = DEF_MISS_END,
  parameter addr_t OVER_START  = DEF_OVER_START,
  parameter addr_t OVER_END    = DEF_OVER_END
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ready,
  input  logic [3:0]        game_state,
  input  logic signed [7:0] rom_data,
  output addr_t             rom_address,
  output addr_t             music_address,
  output logic signed [7:0] audio_out,
  output logic              sfx_active
);

  seq_state_e state_q, state_d;
  logic [3:0] gs_q;
  addr_t      music_q, music_d;
  addr_t      ptr_q, ptr_d;
  addr_t      end_q, end_d;
  logic       sfx_q;

  logic       trig;
  clip_t      trig_clip;
  seq_state_e eff_state;
  addr_t      eff_ptr;
  addr_t      eff_end;

  logic       mute;
  addr_t      fetch_addr;

  always_comb begin
    trig      = 1'b0;
    trig_clip = '0;
    if (game_state != gs_q) begin
      unique case (1'b1)
        (game_state == GS_WHACKED): begin
          trig      = 1'b1;
          trig_clip = '{start: WHACK_START, last: WHACK_END};
        end
        (game_state == GS_MISSED): begin
          trig      = 1'b1;
          trig_clip = '{start: MISS_START, last: MISS_END};
        end
        (game_state == GS_GAME_OVER): begin
          trig      = 1'b1;
          trig_clip = '{start: OVER_START, last: OVER_END};
        end
        default: ;
      endcase
    end
  end

  // A trigger takes effect before any ready seen in the same cycle.
  always_comb begin
    eff_state = trig ? SEQ_SFX : state_q;
    eff_ptr   = trig ? trig_clip.start : ptr_q;
    eff_end   = trig ? trig_clip.last : end_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SEQ_SILENT;
      gs_q    <= '0;
      music_q <= MUSIC_START;
      ptr_q   <= '0;
      end_q   <= '0;
      sfx_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gs_q    <= game_state;
      music_q <= music_d;
      ptr_q   <= ptr_d;
      end_q   <= end_d;
      sfx_q   <= (state_d == SEQ_SFX);
    end
  end

  always_comb begin
    state_d = eff_state;
    unique case (eff_state)
      SEQ_SILENT: begin
        if (is_audible(game_state)) begin
          state_d = SEQ_MUSIC;
        end
      end
      SEQ_MUSIC: begin
        if (is_quiet(game_state)) begin
          state_d = SEQ_SILENT;
        end
      end
      SEQ_SFX: begin
        if (ready && eff_ptr == eff_end) begin
          state_d = ends_silent(game_state)
                  ? SEQ_SILENT : SEQ_MUSIC;
        end
      end
      default: state_d = SEQ_SILENT;
    endcase
  end

  always_comb begin
    music_d    = music_q;
    ptr_d      = eff_ptr;
    end_d      = eff_end;
    mute       = 1'b0;
    fetch_addr = music_q;
    unique case (eff_state)
      SEQ_SILENT: begin
        mute = 1'b1;
        if (is_quiet(game_state)) begin
          music_d = MUSIC_START;
        end
      end
      SEQ_MUSIC: begin
        if (is_quiet(game_state)) begin
          mute    = 1'b1;
          music_d = MUSIC_START;
        end else if (ready) begin
          music_d = (music_q == MUSIC_END)
                  ? MUSIC_START
                  : music_q + addr_t'(1);
        end
      end
      SEQ_SFX: begin
        fetch_addr = eff_ptr;
        if (ready) begin
          ptr_d = eff_ptr + addr_t'(1);
        end
      end
      default: mute = 1'b1;
    endcase
  end

  sample_fetch #(
    .RESET_ADDR (MUSIC_START)
  ) u_fetch (
    .clk           (clk),
    .rst_n         (reset_n),
    .ready_i       (ready),
    .mute_i        (mute),
    .addr_i        (fetch_addr),
    .rom_data_i    (rom_data),
    .rom_address_o (rom_address),
    .sample_o      (audio_out)
  );

  assign music_address = music_q;
  assign sfx_active    = sfx_q;

endmodule

// File: tb/tb_audio_sequencer.sv
// Scoreboard bench for audio_sequencer with a 2-cycle ROM model.
module tb_audio_sequencer;

  localparam logic [22:0] M_START = 23'h000000;
  localparam logic [22:0] M_END   = 23'h0000FF;
  localparam logic [22:0] W_START = 23'h50000;
  localparam logic [22:0] W_END   = 23'h51FFF;
  localparam logic [22:0] S_START = 23'h52000;
  localparam logic [22:0] O_START = 23'h54000;
  localparam logic [22:0] O_END   = 23'h57FFF;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              ready;
  logic [3:0]        game_state;
  logic signed [7:0] rom_data;
  logic [22:0]       rom_address;
  logic [22:0]       music_address;
  logic signed [7:0] audio_out;
  logic              sfx_active;
  logic [7:0]        rom_q;

  typedef struct {
    int         due;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   n_cmp;
  int   n_bad;

  always #5 clk = ~clk;

  audio_sequencer #(
    .MUSIC_START (M_START),
    .MUSIC_END   (M_END)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .ready         (ready),
    .game_state    (game_state),
    .rom_data      (rom_data),
    .rom_address   (rom_address),
    .music_address (music_address),
    .audio_out     (audio_out),
    .sfx_active    (sfx_active)
  );

  function automatic logic [7:0] rom_f(logic [22:0] a);
    return a[7:0] ^ a[15:8] ^ {1'b0, a[22:16]} ^ 8'h5A;
  endfunction

  always @(posedge clk) rom_q <= rom_f(rom_address);
  assign rom_data = rom_q;

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      n_cmp++;
      if (audio_out !== e.val) begin
        n_bad++;
        $display("FAIL capture: audio_out=%h required=%h cyc=%0d",
                 audio_out, e.val, cyc);
      end
    end
  endtask

  task automatic pulse(input logic [22:0] a, input bit mute);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    sb.push_back('{due: cyc + 2, val: mute ? 8'h00 : rom_f(a)});
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    ready = 1'b0;
    game_state = 4'd0;
    repeat (3) tick();
    n_cmp += 4;
    if (rom_address !== M_START) begin
      n_bad++;
      $display("FAIL rst_rom: got=%h required=%h", rom_address, M_START);
    end
    if (music_address !== M_START) begin
      n_bad++;
      $display("FAIL rst_music: got=%h required=%h", music_address, M_START);
    end
    if (audio_out !== 8'sd0) begin
      n_bad++;
      $display("FAIL rst_audio: got=%h required=00", audio_out);
    end
    if (sfx_active !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_sfx: got=%b required=0", sfx_active);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_music();
    game_state = 4'd2;
    tick();
    for (int i = 0; i < 5; i++) begin
      pulse(23'(i), 1'b0);
      n_cmp++;
      if (rom_address !== 23'(i)) begin
        n_bad++;
        $display("FAIL music_fetch: got=%h required=%h", rom_address, i);
      end
      tick();
    end
    n_cmp++;
    if (music_address !== 23'd5) begin
      n_bad++;
      $display("FAIL music_pos: got=%h required=5", music_address);
    end
  endtask

  task automatic test_wrap();
    for (int i = 5; i <= 255; i++) begin
      pulse(23'(i), 1'b0);
      n_cmp++;
      if (rom_address !== 23'(i)) begin
        n_bad++;
        $display("FAIL wrap_fetch: got=%h required=%h", rom_address, i);
      end
      tick();
    end
    n_cmp++;
    if (music_address !== M_START) begin
      n_bad++;
      $display("FAIL wrap: got=%h required=%h", music_address, M_START);
    end
    for (int i = 0; i < 100; i++) begin
      pulse(23'(i), 1'b0);
      n_cmp++;
      if (rom_address !== 23'(i)) begin
        n_bad++;
        $display("FAIL refill_fetch: got=%h required=%h", rom_address, i);
      end
      tick();
    end
    n_cmp++;
    if (music_address !== 23'd100) begin
      n_bad++;
      $display("FAIL refill_pos: got=%h required=64", music_address);
    end
  endtask

  task automatic test_whack();
    game_state = 4'd4;
    tick();
    game_state = 4'd6;
    tick();
    n_cmp++;
    if (sfx_active !== 1'b1) begin
      n_bad++;
      $display("FAIL whack_sfx: got=%b required=1", sfx_active);
    end
    for (int i = 0; i < 8192; i++) begin
      pulse(W_START + 23'(i), 1'b0);
      n_cmp++;
      if (rom_address !== W_START + 23'(i)) begin
        n_bad++;
        $display("FAIL whack_fetch: got=%h required=%h",
                 rom_address, W_START + 23'(i));
      end
      tick();
    end
    n_cmp += 2;
    if (sfx_active !== 1'b0) begin
      n_bad++;
      $display("FAIL whack_done: sfx=%b required=0", sfx_active);
    end
    if (music_address !== 23'd100) begin
      n_bad++;
      $display("FAIL whack_hold: got=%h required=64", music_address);
    end
    pulse(23'd100, 1'b0);
    n_cmp++;
    if (rom_address !== 23'd100) begin
      n_bad++;
      $display("FAIL resume_fetch: got=%h required=64", rom_address);
    end
    tick();
  endtask

  task automatic test_same_cycle();
    game_state = 4'd4;
    tick();
    game_state = 4'd6;
    tick();
    for (int i = 0; i < 10; i++) begin
      pulse(W_START + 23'(i), 1'b0);
      tick();
    end
    game_state = 4'd5;
    pulse(S_START, 1'b0);
    n_cmp++;
    if (rom_address !== S_START) begin
      n_bad++;
      $display("FAIL same_cycle: got=%h required=%h", rom_address, S_START);
    end
    tick();
    pulse(S_START + 23'd1, 1'b0);
    n_cmp += 2;
    if (rom_address !== S_START + 23'd1) begin
      n_bad++;
      $display("FAIL miss_next: got=%h required=%h",
               rom_address, S_START + 23'd1);
    end
    if (sfx_active !== 1'b1) begin
      n_bad++;
      $display("FAIL miss_sfx: got=%b required=1", sfx_active);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    ready = 1'b1;
    tick();
    ready = 1'b0;
    #2;
    reset_n = 1'b0;
    game_state = 4'd0;
    #1;
    n_cmp += 4;
    if (rom_address !== M_START) begin
      n_bad++;
      $display("FAIL mid_rom: got=%h required=%h", rom_address, M_START);
    end
    if (music_address !== M_START) begin
      n_bad++;
      $display("FAIL mid_music: got=%h required=%h", music_address, M_START);
    end
    if (audio_out !== 8'sd0) begin
      n_bad++;
      $display("FAIL mid_audio: got=%h required=00", audio_out);
    end
    if (sfx_active !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_sfx: got=%b required=0", sfx_active);
    end
    sb.delete();
    repeat (2) tick();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp += 2;
      if (audio_out !== 8'sd0) begin
        n_bad++;
        $display("FAIL stale_capture: got=%h required=00", audio_out);
      end
      if (sfx_active !== 1'b0) begin
        n_bad++;
        $display("FAIL post_rst_sfx: got=%b required=0", sfx_active);
      end
    end
  endtask

  task automatic test_over();
    game_state = 4'd2;
    tick();
    game_state = 4'd4;
    for (int i = 0; i < 3; i++) begin
      pulse(23'(i), 1'b0);
      tick();
    end
    game_state = 4'd8;
    tick();
    n_cmp++;
    if (sfx_active !== 1'b1) begin
      n_bad++;
      $display("FAIL over_sfx: got=%b required=1", sfx_active);
    end
    for (int i = 0; i < 16384; i++) begin
      pulse(O_START + 23'(i), 1'b0);
      n_cmp++;
      if (rom_address !== O_START + 23'(i)) begin
        n_bad++;
        $display("FAIL over_fetch: got=%h required=%h",
                 rom_address, O_START + 23'(i));
      end
      tick();
    end
    n_cmp++;
    if (sfx_active !== 1'b0) begin
      n_bad++;
      $display("FAIL over_done: sfx=%b required=0", sfx_active);
    end
    pulse(O_END, 1'b1);
    n_cmp++;
    if (rom_address !== O_END) begin
      n_bad++;
      $display("FAIL silent_hold: got=%h required=%h", rom_address, O_END);
    end
    repeat (3) tick();
    n_cmp += 2;
    if (audio_out !== 8'sd0) begin
      n_bad++;
      $display("FAIL silent_audio: got=%h required=00", audio_out);
    end
    if (music_address !== 23'd3) begin
      n_bad++;
      $display("FAIL over_hold: got=%h required=3", music_address);
    end
    game_state = 4'd0;
    tick();
    n_cmp++;
    if (music_address !== M_START) begin
      n_bad++;
      $display("FAIL idle_rewind: got=%h required=%h",
               music_address, M_START);
    end
  endtask

  task automatic test_reset_trigger();
    game_state = 4'd6;
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    n_cmp++;
    if (sfx_active !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_trigger: sfx=%b required=1", sfx_active);
    end
    pulse(W_START, 1'b0);
    n_cmp++;
    if (rom_address !== W_START) begin
      n_bad++;
      $display("FAIL rst_trig_fetch: got=%h required=%h",
               rom_address, W_START);
    end
    repeat (3) tick();
  endtask

  initial begin
    cyc   = 0;
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_music();
    test_wrap();
    test_whack();
    test_same_cycle();
    test_reset_mid();
    test_over();
    test_reset_trigger();
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d captures never checked", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
